alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Decode/execute pipeline stage that sits directly upstream of the ALU; it drives the ALU's A, B, opcode and carry-in.
- Accepts decoded instructions over a valid/ready handshake and resolves operand forwarding from the EX and WB stages.
- Builds immediate and shift operands, detects load-use hazards and inserts bubbles.
- Holds one registered instruction; ALU inputs come straight from this register.

Parameters:
- DATA_W, 32, operand width (ALU is 32-bit)
- IDX_W, 5, register index width
- OP_W, 6, ALU opcode width
- STALL_CNT_W, 16, width of saturating hazard-stall counter

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- rs_idx, rt_idx  in  IDX_W each  source register indices
- rs_data, rt_data  in  DATA_W each  register-file read data
- rt_used  in  1  instruction reads rt as a source
- imm16  in  16  immediate field
- shamt  in  5  shift-amount field
- use_imm  in  1  B comes from the extended immediate
- imm_signed  in  1  1 = sign-extend imm16, 0 = zero-extend
- is_lui  in  1  load-upper-immediate
- is_shift  in  1  shift instruction
- shift_var  in  1  shift amount from rs[4:0] instead of shamt
- alu_op_in  in  OP_W  ALU opcode from decode
- carry_in  in  1  carry input for the ALU
- dest_idx_in  in  IDX_W  destination register
- ex_fwd_valid  in  1  EX stage writes ex_fwd_idx
- ex_fwd_idx  in  IDX_W
- ex_fwd_data  in  DATA_W
- ex_is_load  in  1  EX-stage instruction is a load (data not yet available)
- wb_fwd_valid  in  1  WB stage writes wb_fwd_idx
- wb_fwd_idx  in  IDX_W
- wb_fwd_data  in  DATA_W
- flush  in  1  kill the held instruction (branch redirect)
- out_valid  out  1  alu_a/alu_b/alu_opcode valid
- out_ready  in  1  downstream consumes the held instruction
- alu_a, alu_b  out  DATA_W each  ALU operands
- alu_opcode  out  OP_W
- alu_carry_in  out  1
- dest_idx  out  IDX_W
- stall_count  out  STALL_CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset: out_valid=0, alu_a=0, alu_b=0, alu_opcode=0, alu_carry_in=0, dest_idx=0, stall_count=0.
- Handshake:
  - hazard = in_valid & ex_fwd_valid & ex_is_load & ex_fwd_idx!=0 & (ex_fwd_idx==rs_idx | (rt_used & ex_fwd_idx==rt_idx)).
  - in_ready = (!out_valid | out_ready) & !hazard & !flush; combinational.
  - Capture when in_valid & in_ready; latency 1 cycle from capture to out_valid.
- Held instruction:
  - out_valid & !out_ready with no flush: all outputs are held stable.
  - out_valid & out_ready with no new capture (including during a hazard): out_valid->0 next cycle, which is the bubble.
- Flush has priority over everything except reset: out_valid->0 next cycle, no capture that cycle; data registers keep their old values.
- Forwarding is resolved at capture, per source:
  - Index 0 is always 0; it is never forwarded and the register-file value is ignored.
  - Otherwise EX match (ex_fwd_valid & !ex_is_load) is used first, then WB match, then the register-file data.
- Operand build, in priority order:
  - is_lui: A=0, B={imm16,16'h0}, opcode forced to OR (000011).
  - is_shift: A=rt value; B = zero-extended (shift_var ? rs value[4:0] : shamt); opcode=alu_op_in.
  - use_imm: A=rs value; B = imm_signed ? sign-extend(imm16) : zero-extend(imm16).
  - else: A=rs value, B=rt value.
- alu_carry_in and dest_idx are registered with the instruction.
- stall_count increments by 1 in each cycle where hazard=1; it saturates at all-ones and does not wrap. It is cleared only by reset.
- Reset asserted mid-operation: the in-flight instruction is dropped; outputs take their reset values next edge.
- Simultaneous EX and WB writes of the same index: EX wins. A WB write in the same cycle as the regfile read is covered by forwarding.

Decomposition:
- alu_pkg holds:
  - opcode constants: ADD 000000, SUB 000001, AND 000010, OR 000011, XOR 000100, SLL 000110, SRL 000111, NOR 001001;
  - DATA_W, IDX_W;
  - ZERO_REG=0.
- Sub-module operand_fwd_mux (combinational: idx, rf_data, EX/WB forward ports -> value), instantiated twice for rs and rt.

Test Plan:
- Plain capture: rs_data=6, rt_data=0x0A, alu_op_in=ADD, no forwarding -> next cycle out_valid=1, alu_a=6, alu_b=0x0A, alu_opcode=000000.
- Forward priority: rs_idx=3; ex_fwd(3, 0x11); wb_fwd(3, 0x22); rs_data=0x33 -> alu_a=0x11. Same with ex_fwd_valid=0 -> alu_a=0x22. With rs_idx=0 and both forwarding idx 0 -> alu_a=0.
- Immediates:
  - imm16=0xFFF0, use_imm, imm_signed=1 -> alu_b=0xFFFFFFF0; imm_signed=0 -> alu_b=0x0000FFF0.
  - is_lui, imm16=0x1234 -> alu_a=0, alu_b=0x12340000, alu_opcode=000011.
- Load-use: ex_fwd_valid=1, ex_is_load=1, ex_fwd_idx=5, rt_used=1, rt_idx=5 for 2 cycles -> in_ready=0 both cycles, out_valid=0 after the held instruction drains, stall_count=2. Then ex_is_load=0 with ex_fwd_data=0x77 -> capture, alu_b=0x77.
- Backpressure and flush:
  - out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
  - flush pulse with in_valid=1 -> out_valid=0 next cycle and the input is not captured.
- Reset mid-stream (out_valid=1, stall_count=4) -> next edge all outputs 0, stall_count=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operand stage: opcode encodings,
// default widths, and the operand-build mode decode.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SLL = 6'b000110;
  localparam logic [5:0] OP_SRL = 6'b000111;
  localparam logic [5:0] OP_NOR = 6'b001001;

  localparam logic [IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    MODE_RR,
    MODE_IMM,
    MODE_SHIFT,
    MODE_LUI
  } operand_mode_e;

  // LUI outranks shift, which outranks the plain immediate form.
  function automatic operand_mode_e decode_mode(input logic is_lui,
                                                input logic is_shift,
                                                input logic use_imm);
    if (is_lui)        return MODE_LUI;
    else if (is_shift) return MODE_SHIFT;
    else if (use_imm)  return MODE_IMM;
    else               return MODE_RR;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: register 0 reads as zero, otherwise the EX
// result (when not a pending load) beats WB, which beats the register file.
module operand_fwd_mux
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int IDX_W  = alu_pkg::IDX_W
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_fwd_valid,
  input  logic              ex_is_load,
  input  logic [IDX_W-1:0]  ex_fwd_idx,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic [IDX_W-1:0]  wb_fwd_idx,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic [DATA_W-1:0] value
);

  logic ex_match;
  logic wb_match;

  assign ex_match = ex_fwd_valid && !ex_is_load && (ex_fwd_idx == idx);
  assign wb_match = wb_fwd_valid && (wb_fwd_idx == idx);

  always_comb begin
    if (idx == IDX_W'(ZERO_REG)) value = '0;
    else if (ex_match)           value = ex_fwd_data;
    else if (wb_match)           value = wb_fwd_data;
    else                         value = rf_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage in front of the ALU: forwards sources, builds immediate/shift
// operands, stalls on load-use hazards and holds one instruction for the ALU.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W      = alu_pkg::DATA_W,
  parameter int IDX_W       = alu_pkg::IDX_W,
  parameter int OP_W        = 6,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDX_W-1:0]       rs_idx,
  input  logic [IDX_W-1:0]       rt_idx,
  input  logic [DATA_W-1:0]      rs_data,
  input  logic [DATA_W-1:0]      rt_data,
  input  logic                   rt_used,
  input  logic [15:0]            imm16,
  input  logic [4:0]             shamt,
  input  logic                   use_imm,
  input  logic                   imm_signed,
  input  logic                   is_lui,
  input  logic                   is_shift,
  input  logic                   shift_var,
  input  logic [OP_W-1:0]        alu_op_in,
  input  logic                   carry_in,
  input  logic [IDX_W-1:0]       dest_idx_in,
  input  logic                   ex_fwd_valid,
  input  logic [IDX_W-1:0]       ex_fwd_idx,
  input  logic [DATA_W-1:0]      ex_fwd_data,
  input  logic                   ex_is_load,
  input  logic                   wb_fwd_valid,
  input  logic [IDX_W-1:0]       wb_fwd_idx,
  input  logic [DATA_W-1:0]      wb_fwd_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OP_W-1:0]        alu_opcode,
  output logic                   alu_carry_in,
  output logic [IDX_W-1:0]       dest_idx,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] next_a;
  logic [DATA_W-1:0] next_b;
  logic [OP_W-1:0]   next_op;
  logic              hazard;
  logic              capture;

  operand_fwd_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_rs_fwd (
    .idx          (rs_idx),
    .rf_data      (rs_data),
    .ex_fwd_valid (ex_fwd_valid),
    .ex_is_load   (ex_is_load),
    .ex_fwd_idx   (ex_fwd_idx),
    .ex_fwd_data  (ex_fwd_data),
    .wb_fwd_valid (wb_fwd_valid),
    .wb_fwd_idx   (wb_fwd_idx),
    .wb_fwd_data  (wb_fwd_data),
    .value        (rs_val)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_rt_fwd (
    .idx          (rt_idx),
    .rf_data      (rt_data),
    .ex_fwd_valid (ex_fwd_valid),
    .ex_is_load   (ex_is_load),
    .ex_fwd_idx   (ex_fwd_idx),
    .ex_fwd_data  (ex_fwd_data),
    .wb_fwd_valid (wb_fwd_valid),
    .wb_fwd_idx   (wb_fwd_idx),
    .wb_fwd_data  (wb_fwd_data),
    .value        (rt_val)
  );

  // A load in EX has no data yet, so any real source that names its target must wait.
  assign hazard = in_valid && ex_fwd_valid && ex_is_load
               && (ex_fwd_idx != IDX_W'(ZERO_REG))
               && ((ex_fwd_idx == rs_idx) || (rt_used && (ex_fwd_idx == rt_idx)));

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign capture  = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal driven here is defaulted first so no path leaves it unassigned (no latch).
    next_a  = rs_val;
    next_b  = rt_val;
    next_op = alu_op_in;
    case (decode_mode(is_lui, is_shift, use_imm))
      MODE_LUI: begin
        next_a  = '0;
        next_b  = DATA_W'({imm16, 16'h0000});
        next_op = OP_W'(OP_OR);
      end
      MODE_SHIFT: begin
        next_a = rt_val;
        next_b = {{(DATA_W-5){1'b0}}, (shift_var ? rs_val[4:0] : shamt)};
      end
      MODE_IMM: begin
        next_b = imm_signed ? {{(DATA_W-16){imm16[15]}}, imm16}
                            : {{(DATA_W-16){1'b0}}, imm16};
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      alu_carry_in <= 1'b0;
      dest_idx     <= '0;
      stall_count  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture) begin
        out_valid    <= 1'b1;
        alu_a        <= next_a;
        alu_b        <= next_b;
        alu_opcode   <= next_op;
        alu_carry_in <= carry_in;
        dest_idx     <= dest_idx_in;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (hazard && (stall_count != '1)) begin
        stall_count <= stall_count + STALL_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vectors, hand-written
// hazard/backpressure/flush/reset sequences, and a randomized model comparison.
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs_idx, rt_idx;
  logic [31:0] rs_data, rt_data;
  logic        rt_used;
  logic [15:0] imm16;
  logic [4:0]  shamt;
  logic        use_imm, imm_signed, is_lui, is_shift, shift_var;
  logic [5:0]  alu_op_in;
  logic        carry_in;
  logic [4:0]  dest_idx_in;
  logic        ex_fwd_valid;
  logic [4:0]  ex_fwd_idx;
  logic [31:0] ex_fwd_data;
  logic        ex_is_load;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_idx;
  logic [31:0] wb_fwd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_opcode;
  logic        alu_carry_in;
  logic [4:0]  dest_idx;
  logic [15:0] stall_count;

  logic        sat_in_ready, sat_out_valid, sat_carry;
  logic [31:0] sat_a, sat_b;
  logic [5:0]  sat_op;
  logic [4:0]  sat_dest;
  logic [2:0]  sat_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_idx(rs_idx), .rt_idx(rt_idx), .rs_data(rs_data), .rt_data(rt_data),
    .rt_used(rt_used), .imm16(imm16), .shamt(shamt), .use_imm(use_imm),
    .imm_signed(imm_signed), .is_lui(is_lui), .is_shift(is_shift),
    .shift_var(shift_var), .alu_op_in(alu_op_in), .carry_in(carry_in),
    .dest_idx_in(dest_idx_in), .ex_fwd_valid(ex_fwd_valid), .ex_fwd_idx(ex_fwd_idx),
    .ex_fwd_data(ex_fwd_data), .ex_is_load(ex_is_load), .wb_fwd_valid(wb_fwd_valid),
    .wb_fwd_idx(wb_fwd_idx), .wb_fwd_data(wb_fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_carry_in(alu_carry_in), .dest_idx(dest_idx),
    .stall_count(stall_count)
  );

  // Narrow-counter instance sharing all inputs, used to reach saturation quickly.
  alu_operand_stage #(.STALL_CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sat_in_ready),
    .rs_idx(rs_idx), .rt_idx(rt_idx), .rs_data(rs_data), .rt_data(rt_data),
    .rt_used(rt_used), .imm16(imm16), .shamt(shamt), .use_imm(use_imm),
    .imm_signed(imm_signed), .is_lui(is_lui), .is_shift(is_shift),
    .shift_var(shift_var), .alu_op_in(alu_op_in), .carry_in(carry_in),
    .dest_idx_in(dest_idx_in), .ex_fwd_valid(ex_fwd_valid), .ex_fwd_idx(ex_fwd_idx),
    .ex_fwd_data(ex_fwd_data), .ex_is_load(ex_is_load), .wb_fwd_valid(wb_fwd_valid),
    .wb_fwd_idx(wb_fwd_idx), .wb_fwd_data(wb_fwd_data), .flush(flush),
    .out_valid(sat_out_valid), .out_ready(out_ready), .alu_a(sat_a), .alu_b(sat_b),
    .alu_opcode(sat_op), .alu_carry_in(sat_carry), .dest_idx(sat_dest),
    .stall_count(sat_stall_count)
  );

  typedef struct {
    logic [4:0]  rs_idx, rt_idx;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm16;
    logic [4:0]  shamt;
    logic        use_imm, imm_signed, is_lui, is_shift, shift_var, carry;
    logic [5:0]  op;
    logic [4:0]  dest;
    logic        ex_v;
    logic [4:0]  ex_idx;
    logic [31:0] ex_data;
    logic        wb_v;
    logic [4:0]  wb_idx;
    logic [31:0] wb_data;
    logic [31:0] exp_a, exp_b;
    logic [5:0]  exp_op;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs_idx = 0; rt_idx = 0; rs_data = 0; rt_data = 0; rt_used = 0;
    imm16 = 0; shamt = 0; use_imm = 0; imm_signed = 0; is_lui = 0; is_shift = 0;
    shift_var = 0; alu_op_in = 0; carry_in = 0; dest_idx_in = 0;
    ex_fwd_valid = 0; ex_fwd_idx = 0; ex_fwd_data = 0; ex_is_load = 0;
    wb_fwd_valid = 0; wb_fwd_idx = 0; wb_fwd_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  function automatic vec_t vdef();
    vec_t v;
    v = '{default: '0};
    v.rs_idx = 1;
    v.rt_idx = 2;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    in_valid = 1; rt_used = 1;
    rs_idx = v.rs_idx; rt_idx = v.rt_idx; rs_data = v.rs_data; rt_data = v.rt_data;
    imm16 = v.imm16; shamt = v.shamt; use_imm = v.use_imm; imm_signed = v.imm_signed;
    is_lui = v.is_lui; is_shift = v.is_shift; shift_var = v.shift_var;
    alu_op_in = v.op; carry_in = v.carry; dest_idx_in = v.dest;
    ex_fwd_valid = v.ex_v; ex_fwd_idx = v.ex_idx; ex_fwd_data = v.ex_data; ex_is_load = 0;
    wb_fwd_valid = v.wb_v; wb_fwd_idx = v.wb_idx; wb_fwd_data = v.wb_data;
  endtask

  task automatic set_hazard_inputs();
    in_valid = 1; rs_idx = 1; rs_data = 32'h10; rt_idx = 5; rt_used = 1; rt_data = 32'h55;
    use_imm = 0; is_lui = 0; is_shift = 0; alu_op_in = OP_ADD;
    ex_fwd_valid = 1; ex_is_load = 1; ex_fwd_idx = 5; ex_fwd_data = 32'hDEAD; wb_fwd_valid = 0;
  endtask

  // Reference model: architectural meaning of each instruction, independent of RTL structure.
  function automatic logic [31:0] model_src(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'h0;
    if (ex_fwd_valid && !ex_is_load && ex_fwd_idx == idx) return ex_fwd_data;
    if (wb_fwd_valid && wb_fwd_idx == idx) return wb_fwd_data;
    return rf;
  endfunction

  task automatic model_build(output logic [31:0] a, output logic [31:0] b, output logic [5:0] op);
    logic [31:0] rsv, rtv;
    logic signed [31:0] simm;
    rsv = model_src(rs_idx, rs_data);
    rtv = model_src(rt_idx, rt_data);
    simm = $signed(imm16);
    op = alu_op_in;
    if (is_lui) begin
      a = 0; b = imm16 * 32'h10000; op = OP_OR;
    end else if (is_shift) begin
      a = rtv; b = shift_var ? (rsv % 32) : 32'(shamt);
    end else if (use_imm) begin
      a = rsv; b = imm_signed ? simm : 32'(imm16);
    end else begin
      a = rsv; b = rtv;
    end
  endtask

  vec_t vecs[9];
  vec_t v;
  logic        m_valid, m_haz, m_rdy, m_carry;
  logic [31:0] m_a, m_b;
  logic [5:0]  m_op;
  logic [4:0]  m_dest;
  int          m_stalls;

  initial begin
    v = vdef(); v.rs_data = 6; v.rt_data = 32'h0A; v.op = OP_ADD; v.dest = 7; v.carry = 1;
    v.exp_a = 6; v.exp_b = 32'h0A; v.exp_op = OP_ADD; vecs[0] = v;
    v = vdef(); v.rs_idx = 3; v.rs_data = 32'h33; v.rt_idx = 4; v.rt_data = 32'h44; v.op = OP_SUB;
    v.ex_v = 1; v.ex_idx = 3; v.ex_data = 32'h11; v.wb_v = 1; v.wb_idx = 3; v.wb_data = 32'h22;
    v.dest = 9; v.exp_a = 32'h11; v.exp_b = 32'h44; v.exp_op = OP_SUB; vecs[1] = v;
    v = vecs[1]; v.ex_v = 0; v.exp_a = 32'h22; vecs[2] = v;
    v = vecs[1]; v.rs_idx = 0; v.ex_idx = 0; v.wb_idx = 0; v.rs_data = 32'h55; v.exp_a = 0; vecs[3] = v;
    v = vdef(); v.rs_data = 32'h1234_5678; v.use_imm = 1; v.imm_signed = 1; v.imm16 = 16'hFFF0;
    v.op = OP_ADD; v.dest = 3; v.exp_a = 32'h1234_5678; v.exp_b = 32'hFFFF_FFF0; v.exp_op = OP_ADD; vecs[4] = v;
    v = vecs[4]; v.imm_signed = 0; v.op = OP_AND; v.exp_b = 32'h0000_FFF0; v.exp_op = OP_AND; vecs[5] = v;
    v = vdef(); v.is_lui = 1; v.imm16 = 16'h1234; v.rs_data = 32'h99; v.op = OP_ADD; v.dest = 4;
    v.exp_a = 0; v.exp_b = 32'h1234_0000; v.exp_op = OP_OR; vecs[6] = v;
    v = vdef(); v.is_shift = 1; v.shamt = 7; v.rt_data = 32'h80; v.rs_data = 32'hFFFF_FF23;
    v.op = OP_SLL; v.carry = 1; v.dest = 30; v.exp_a = 32'h80; v.exp_b = 7; v.exp_op = OP_SLL; vecs[7] = v;
    v = vecs[7]; v.shift_var = 1; v.op = OP_SRL; v.exp_b = 3; v.exp_op = OP_SRL; vecs[8] = v;

    do_reset();

    check("reset_out_valid", out_valid, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    check("reset_opcode", alu_opcode, 0);
    check("reset_carry", alu_carry_in, 0);
    check("reset_dest", dest_idx, 0);
    check("reset_stall_count", stall_count, 0);
    check("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      drive_vec(vecs[i]);
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      tick();
      check($sformatf("vec%0d_out_valid", i), out_valid, 1);
      check($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].exp_a);
      check($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].exp_b);
      check($sformatf("vec%0d_opcode", i), alu_opcode, vecs[i].exp_op);
      check($sformatf("vec%0d_carry", i), alu_carry_in, vecs[i].carry);
      check($sformatf("vec%0d_dest", i), dest_idx, vecs[i].dest);
    end

    // Load-use: two stalled cycles, held instruction drains, then EX data forwards.
    set_hazard_inputs();
    #1;
    check("lu_in_ready_c1", in_ready, 0);
    tick();
    check("lu_bubble", out_valid, 0);
    check("lu_in_ready_c2", in_ready, 0);
    tick();
    check("lu_out_valid_c2", out_valid, 0);
    check("lu_stall_count", stall_count, 2);
    ex_is_load = 0; ex_fwd_data = 32'h77;
    #1;
    check("lu_release_ready", in_ready, 1);
    tick();
    check("lu_capture_valid", out_valid, 1);
    check("lu_alu_b_fwd", alu_b, 32'h77);
    check("lu_alu_a", alu_a, 32'h10);
    check("lu_stall_hold", stall_count, 2);

    // Backpressure: held outputs stay put while a different instruction waits.
    out_ready = 0; ex_fwd_valid = 0; rs_data = 32'h99; rt_idx = 2; rt_data = 32'hAB;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
      tick();
      check($sformatf("bp_valid_%0d", i), out_valid, 1);
      check($sformatf("bp_alu_a_%0d", i), alu_a, 32'h10);
      check($sformatf("bp_alu_b_%0d", i), alu_b, 32'h77);
    end

    // Flush beats capture and leaves the data registers alone.
    flush = 1; in_valid = 1;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    check("flush_out_valid", out_valid, 0);
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    check("flush_no_capture", out_valid, 0);
    check("flush_data_kept", alu_a, 32'h10);

    // Reset in the middle of a held instruction with accumulated stalls.
    idle_inputs();
    in_valid = 1; rs_idx = 1; rs_data = 32'h21; rt_idx = 2; rt_data = 32'h22; rt_used = 1;
    tick();
    check("mid_capture", out_valid, 1);
    out_ready = 0;
    set_hazard_inputs();
    tick();
    tick();
    check("mid_stall_count", stall_count, 4);
    check("mid_held_valid", out_valid, 1);
    reset = 1; ex_is_load = 0; ex_fwd_valid = 0; out_ready = 1; in_valid = 1;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_opcode", alu_opcode, 0);
    check("mid_rst_dest", dest_idx, 0);
    check("mid_rst_stall", stall_count, 0);
    reset = 0;

    // Saturation: the 3-bit counter must stick at 7 while the 16-bit one keeps counting.
    idle_inputs();
    set_hazard_inputs();
    for (int i = 0; i < 10; i++) tick();
    check("sat_wide_count", stall_count, 10);
    check("sat_narrow_count", sat_stall_count, 7);

    // Randomized traffic against the reference model.
    do_reset();
    m_valid = 0; m_stalls = 0; m_a = 0; m_b = 0; m_op = 0; m_carry = 0; m_dest = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = ($urandom % 4) != 0;
      rs_idx = 5'($urandom % 8); rt_idx = 5'($urandom % 8);
      rs_data = $urandom; rt_data = $urandom; rt_used = 1'($urandom % 2);
      imm16 = 16'($urandom); shamt = 5'($urandom);
      use_imm = 1'($urandom % 2); imm_signed = 1'($urandom % 2);
      is_lui = ($urandom % 8) == 0; is_shift = ($urandom % 4) == 0; shift_var = 1'($urandom % 2);
      alu_op_in = 6'($urandom); carry_in = 1'($urandom % 2); dest_idx_in = 5'($urandom);
      ex_fwd_valid = 1'($urandom % 2); ex_fwd_idx = 5'($urandom % 8); ex_fwd_data = $urandom;
      ex_is_load = ($urandom % 4) == 0;
      wb_fwd_valid = 1'($urandom % 2); wb_fwd_idx = 5'($urandom % 8); wb_fwd_data = $urandom;
      flush = ($urandom % 16) == 0; out_ready = ($urandom % 4) != 0;
      #1;
      m_haz = in_valid && ex_fwd_valid && ex_is_load && ex_fwd_idx != 0 &&
              (ex_fwd_idx == rs_idx || (rt_used && ex_fwd_idx == rt_idx));
      m_rdy = (!m_valid || out_ready) && !m_haz && !flush;
      check("rand_in_ready", in_ready, m_rdy);
      if (m_haz) m_stalls++;
      if (flush) m_valid = 0;
      else if (in_valid && m_rdy) begin
        m_valid = 1;
        model_build(m_a, m_b, m_op);
        m_carry = carry_in;
        m_dest = dest_idx_in;
      end else if (out_ready) m_valid = 0;
      tick();
      check("rand_out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("rand_alu_a", alu_a, m_a);
        check("rand_alu_b", alu_b, m_b);
        check("rand_opcode", alu_opcode, m_op);
        check("rand_carry", alu_carry_in, m_carry);
        check("rand_dest", dest_idx, m_dest);
      end
      check("rand_stall_count", stall_count, (m_stalls > 65535) ? 65535 : m_stalls);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
